// File: rtl/select_3_1_rr_arbiter_pkg.sv
// select_3_1_rr_arbiter_pkg: state encodings, reset constants and round-robin helpers
package select_3_1_rr_arbiter_pkg;
    localparam int NUM_REQ = 3;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    // Pointer starts on the last requester so requester 0 wins the first arbitration
    localparam logic [1:0] RR_PTR_RST = 2'd2;
    // One-hot winner, searching ptr+1, ptr+2, ptr (mod NUM_REQ)
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [1:0] ptr, input logic [NUM_REQ-1:0] valid);
        logic [NUM_REQ-1:0] g;
        g = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (int'(ptr) + k) % NUM_REQ;
            if (g == '0 && valid[c]) g[c] = 1'b1;
        end
        return g;
    endfunction
    function automatic logic [1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
        return oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/select_3_1_rr_arbiter_if.sv
// select_3_1_rr_arbiter_if: requester/sink bundle of the 3:1 round-robin arbiter
//   req_valid/req_last/req_data0..2 : producer beats in, req_ready : per-requester accept
//   out_valid/out_data/out_ready    : registered output stage, grant : one-hot owner
interface select_3_1_rr_arbiter_if #(parameter int dwidth = 32);
    logic [2:0]        req_valid;
    logic [2:0]        req_last;
    logic [2:0]        req_ready;
    logic [dwidth-1:0] req_data0;
    logic [dwidth-1:0] req_data1;
    logic [dwidth-1:0] req_data2;
    logic              out_valid;
    logic [dwidth-1:0] out_data;
    logic              out_ready;
    logic [2:0]        grant;
    modport slave (
        input  req_valid, req_last, req_data0, req_data1, req_data2, out_ready,
        output req_ready, out_valid, out_data, grant
    );
    modport master (
        output req_valid, req_last, req_data0, req_data1, req_data2, out_ready,
        input  req_ready, out_valid, out_data, grant
    );
endinterface

// File: rtl/select_3_1_rr_arbiter_wn.sv
// select_3_1_wn: 3:1 AND-OR data select driven by one-hot enables
//   enable0_i..enable2_i : one-hot enables, data0_i..data2_i : inputs, data_o : selected word
module select_3_1_wn #(
    parameter int dwidth = 32
) (
    input  logic              enable0_i,
    input  logic              enable1_i,
    input  logic              enable2_i,
    input  logic [dwidth-1:0] data0_i,
    input  logic [dwidth-1:0] data1_i,
    input  logic [dwidth-1:0] data2_i,
    output logic [dwidth-1:0] data_o
);
    assign data_o = ({dwidth{enable0_i}} & data0_i) |
                    ({dwidth{enable1_i}} & data1_i) |
                    ({dwidth{enable2_i}} & data2_i);
endmodule

// File: rtl/select_3_1_rr_arbiter.sv
// select_3_1_rr_arbiter: burst-locked round-robin arbiter feeding a one-entry output register
//   clk : rising-edge clock, reset_n : async active-low reset
//   bus : slave side of select_3_1_rr_arbiter_if (three requesters in, one sink out)
module select_3_1_rr_arbiter
    import select_3_1_rr_arbiter_pkg::*;
#(
    parameter int dwidth         = 32,
    parameter int idle_limit     = 15,
    parameter int idle_cnt_width = 4
) (
    input logic                      clk,
    input logic                      reset_n,
    select_3_1_rr_arbiter_if.slave   bus
);
    state_t                    state_q, state_d;
    logic [2:0]                grant_q, grant_d;
    logic [1:0]                rr_ptr_q, rr_ptr_d;
    logic [idle_cnt_width-1:0] idle_cnt_q, idle_cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic [dwidth-1:0]         out_data_q, out_data_d;
    logic [dwidth-1:0]         sel_data;
    logic [2:0]                en;
    logic                      busy, slot_free, owner_valid, owner_last, xfer, idle_hit;

    assign busy        = state_q == BUSY;
    // Enables only while BUSY, so the mux never drives a captured value in IDLE
    assign en          = busy ? grant_q : 3'b000;
    assign slot_free   = !out_valid_q || bus.out_ready;
    assign owner_valid = |(bus.req_valid & en);
    assign owner_last  = |(bus.req_last & en);
    assign xfer        = owner_valid && slot_free;
    assign idle_hit    = idle_cnt_q == idle_cnt_width'(idle_limit - 1);

    assign bus.req_ready = slot_free ? en : 3'b000;
    assign bus.grant     = grant_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    select_3_1_wn #(.dwidth(dwidth)) u_sel (
        .enable0_i (en[0]),
        .enable1_i (en[1]),
        .enable2_i (en[2]),
        .data0_i   (bus.req_data0),
        .data1_i   (bus.req_data1),
        .data2_i   (bus.req_data2),
        .data_o    (sel_data)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        idle_cnt_d  = idle_cnt_q;
        out_valid_d = xfer || (out_valid_q && !bus.out_ready);
        out_data_d  = xfer ? sel_data : out_data_q;
        if (!busy) begin
            if (|bus.req_valid) begin
                grant_d = rr_pick(rr_ptr_q, bus.req_valid);
                state_d = BUSY;
            end
        end else if ((xfer && owner_last) || (!owner_valid && idle_hit)) begin
            // Burst end or stalled owner: release and rotate past the old owner
            state_d    = IDLE;
            grant_d    = 3'b000;
            rr_ptr_d   = oh2idx(grant_q);
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = owner_valid ? '0 : idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= 3'b000;
            rr_ptr_q    <= RR_PTR_RST;
            idle_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            idle_cnt_q  <= idle_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_select_3_1_rr_arbiter.sv
// tb_select_3_1_rr_arbiter: directed table, corner sequences and random traffic against a reference model
module tb_select_3_1_rr_arbiter;
    localparam int IDLE_LIMIT = 15;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    select_3_1_rr_arbiter_if #(.dwidth(32)) bus ();
    select_3_1_rr_arbiter #(.dwidth(32), .idle_limit(IDLE_LIMIT), .idle_cnt_width(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    // Reference model: owner index (-1 = none), last owner, stalled-cycle count, output slot
    int m_own, m_ptr, m_idle;
    bit m_ov, m_x;
    logic [31:0] m_od;
    logic [7:0] seq [3];
    logic [2:0] last_acc;

    typedef struct {
        logic [2:0] v;
        logic [2:0] l;
        logic r;
        logic [2:0] g;
        logic [2:0] rdy;
        logic ov;
        logic [31:0] od;
    } vec_t;
    vec_t tab [8];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [31:0] dsel(input int i);
        return i == 0 ? bus.req_data0 : i == 1 ? bus.req_data1 : bus.req_data2;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_own = -1; m_ptr = 2; m_idle = 0; m_ov = 0; m_od = '0;
        end else begin
            m_x = m_own >= 0 && bus.req_valid[m_own] && (!m_ov || bus.out_ready);
            if (m_x) begin
                m_ov = 1; m_od = dsel(m_own);
            end else if (bus.out_ready) m_ov = 0;
            if (m_own < 0) begin
                for (int k = 1; k <= 3; k++)
                    if (m_own < 0 && bus.req_valid[(m_ptr + k) % 3]) m_own = (m_ptr + k) % 3;
            end else if (m_x && bus.req_last[m_own]) begin
                m_ptr = m_own; m_own = -1; m_idle = 0;
            end else if (!bus.req_valid[m_own]) begin
                m_idle++;
                if (m_idle == IDLE_LIMIT) begin
                    m_ptr = m_own; m_own = -1; m_idle = 0;
                end
            end else m_idle = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            chk("m_grant", 32'(bus.grant), m_own < 0 ? 32'd0 : 32'(1 << m_own));
            chk("m_ready", 32'(bus.req_ready),
                (m_own >= 0 && (!m_ov || bus.out_ready)) ? 32'(1 << m_own) : 32'd0);
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_ov));
            chk("m_out_data", bus.out_data, m_od);
            chk("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
        end
    end

    task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic r);
        bus.req_valid = v; bus.req_last = l; bus.out_ready = r;
    endtask

    task automatic set_data();
        bus.req_data0 = {16'h0, 8'h00, seq[0]};
        bus.req_data1 = {16'h0, 8'h01, seq[1]};
        bus.req_data2 = {16'h0, 8'h02, seq[2]};
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic step();
        @(negedge clk);
        last_acc = bus.req_ready & bus.req_valid;
        tick();
        for (int i = 0; i < 3; i++) if (last_acc[i]) seq[i]++;
        set_data();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(3'b000, 3'b000, 1'b1);
        seq[0] = 8'h0; seq[1] = 8'h0; seq[2] = 8'h0;
        last_acc = 3'b000;
        set_data();
        tick(); tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int it, n;
        logic [31:0] held;
        tab[0] = '{3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 32'h00};
        tab[1] = '{3'b111, 3'b111, 1'b1, 3'b001, 3'b001, 1'b0, 32'h00};
        tab[2] = '{3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b1, 32'hA0};
        tab[3] = '{3'b111, 3'b111, 1'b1, 3'b010, 3'b010, 1'b0, 32'hA0};
        tab[4] = '{3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b1, 32'hB1};
        tab[5] = '{3'b111, 3'b111, 1'b1, 3'b100, 3'b100, 1'b0, 32'hB1};
        tab[6] = '{3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b1, 32'hC2};
        tab[7] = '{3'b111, 3'b111, 1'b1, 3'b001, 3'b001, 1'b0, 32'hC2};
        do_reset();
        chk_en = 1'b1;
        bus.req_data0 = 32'hA0; bus.req_data1 = 32'hB1; bus.req_data2 = 32'hC2;
        for (int i = 0; i < 8; i++) begin
            drive(tab[i].v, tab[i].l, tab[i].r);
            @(negedge clk);
            chk($sformatf("t1_grant[%0d]", i), 32'(bus.grant), 32'(tab[i].g));
            chk($sformatf("t1_ready[%0d]", i), 32'(bus.req_ready), 32'(tab[i].rdy));
            chk($sformatf("t1_ov[%0d]", i), 32'(bus.out_valid), 32'(tab[i].ov));
            chk($sformatf("t1_od[%0d]", i), bus.out_data, tab[i].od);
            tick();
        end
        // 4-beat burst from requester 1 while 0 and 2 wait with single beats
        seq[1] = 8'h10; set_data();
        drive(3'b111, 3'b101, 1'b1);
        it = 0;
        while (seq[1] < 8'h14 && it < 20) begin
            bus.req_last[1] = seq[1] == 8'h13;
            step();
            it++;
        end
        chk("b2_beats", 32'(seq[1]), 32'h14);
        chk("b2_iters", 32'(it), 32'd5);
        @(negedge clk); chk("b2_idle", 32'(bus.grant), 32'd0);
        tick();
        @(negedge clk); chk("b2_next", 32'(bus.grant), 32'b100);
        tick();
        // Backpressure mid-burst: output held, no ready to the owner
        do_reset();
        drive(3'b001, 3'b000, 1'b1);
        step(); step(); step();
        bus.out_ready = 1'b0;
        @(negedge clk); held = bus.out_data;
        chk("bp_full", 32'(bus.out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("bp_hold", bus.out_data, held);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1; bus.req_last = 3'b001;
        step();
        chk("bp_beats", 32'(seq[0]), 32'd3);
        step();
        // Owner stalls after one beat: grant revoked after IDLE_LIMIT stalled cycles
        do_reset();
        drive(3'b001, 3'b000, 1'b1);
        step(); step();
        bus.req_valid = 3'b110;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.grant != 3'b001) break;
            n++;
            tick();
        end
        chk("idle_revoke", 32'(n), 32'(IDLE_LIMIT));
        chk("idle_gap", 32'(bus.grant), 32'd0);
        tick();
        @(negedge clk); chk("idle_next", 32'(bus.grant), 32'b010);
        tick();
        // Asynchronous reset mid-burst, off the clock edge
        do_reset();
        drive(3'b001, 3'b000, 1'b1);
        step(); step(); step();
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_od", bus.out_data, 32'd0);
        drive(3'b111, 3'b111, 1'b1);
        tick();
        reset_n = 1'b1;
        @(negedge clk); chk("rst_idle", 32'(bus.grant), 32'd0);
        tick();
        @(negedge clk); chk("rst_first", 32'(bus.grant), 32'b001);
        tick();
        // Random streams: valid/last held until accepted, random sink backpressure
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!bus.req_valid[i] || last_acc[i]) begin
                    bus.req_valid[i] = $urandom_range(0, 9) < 6;
                    bus.req_last[i] = $urandom_range(0, 3) == 0;
                end
            end
            bus.out_ready = $urandom_range(0, 9) < 7;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
